uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_rx_pkt_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// UART packet receiver: hunts for a 0xA5 header, collects LEN payload bytes plus an XOR checksum,
// then replays the verified payload on a valid/ready stream with sof/eof/len framing.
module uart_rx_pkt_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_i,
    input  logic       rx_vld_i,
    output logic       rx_rdy_o,
    input  logic       rx_frame_error_i,
    output logic [7:0] pkt_data_o,
    output logic       pkt_vld_o,
    input  logic       pkt_rdy_i,
    output logic       pkt_sof_o,
    output logic       pkt_eof_o,
    output logic [4:0] pkt_len_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_FRAME = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_TOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_OUT
    } state_t;

    state_t        state;
    logic [4:0]    len;
    logic [3:0]    wr_idx;
    logic [3:0]    rd_idx;
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic          fe_q;
    logic [7:0]    buffer [16];

    logic       accept;
    logic       in_frame;
    logic       fe_edge;
    logic       timeout;
    logic       xfer;
    logic [3:0] rd_next;

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign accept   = rx_vld_i && (state != S_OUT);
    assign fe_edge  = rx_frame_error_i && !fe_q;
    assign timeout  = (timer == TIMER_LAST);
    assign xfer     = pkt_vld_o && pkt_rdy_i;
    assign rd_next  = rd_idx + 4'd1;

    // Ready drops with rst so nothing is accepted before the state register is known.
    assign rx_rdy_o = !rst && (state != S_OUT);
    assign busy_o   = !rst && (state != S_HUNT);

    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && accept) begin
            buffer[wr_idx] <= rx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HUNT;
            len        <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            csum       <= '0;
            timer      <= '0;
            fe_q       <= 1'b0;
            pkt_data_o <= '0;
            pkt_vld_o  <= 1'b0;
            pkt_sof_o  <= 1'b0;
            pkt_eof_o  <= 1'b0;
            pkt_len_o  <= '0;
            err_o      <= 1'b0;
            err_code_o <= '0;
        end else begin
            fe_q  <= rx_frame_error_i;
            err_o <= 1'b0;
            // Frame-error edge beats a same-cycle byte; a same-cycle byte beats the timeout.
            if (in_frame && fe_edge) begin
                state      <= S_HUNT;
                timer      <= '0;
                err_o      <= 1'b1;
                err_code_o <= ERR_FRAME;
            end else if (in_frame && !accept && timeout) begin
                state      <= S_HUNT;
                timer      <= '0;
                err_o      <= 1'b1;
                err_code_o <= ERR_TOUT;
            end else begin
                case (state)
                    S_HUNT: begin
                        timer <= '0;
                        if (accept && rx_data_i == HEADER) begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (accept) begin
                            timer <= '0;
                            if (rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
                                state      <= S_HUNT;
                                err_o      <= 1'b1;
                                err_code_o <= ERR_LEN;
                            end else begin
                                len    <= rx_data_i[4:0];
                                csum   <= rx_data_i;
                                wr_idx <= '0;
                                state  <= S_PAYLOAD;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (accept) begin
                            timer  <= '0;
                            csum   <= csum ^ rx_data_i;
                            wr_idx <= wr_idx + 4'd1;
                            if ({1'b0, wr_idx} == len - 5'd1) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_CSUM: begin
                        if (accept) begin
                            timer <= '0;
                            if (rx_data_i == csum) begin
                                state      <= S_OUT;
                                rd_idx     <= '0;
                                pkt_vld_o  <= 1'b1;
                                pkt_data_o <= buffer[0];
                                pkt_sof_o  <= 1'b1;
                                pkt_eof_o  <= (len == 5'd1);
                                pkt_len_o  <= len;
                            end else begin
                                state      <= S_HUNT;
                                err_o      <= 1'b1;
                                err_code_o <= ERR_CSUM;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_OUT: begin
                        timer <= '0;
                        if (xfer) begin
                            if (pkt_eof_o) begin
                                state     <= S_HUNT;
                                pkt_vld_o <= 1'b0;
                                pkt_sof_o <= 1'b0;
                                pkt_eof_o <= 1'b0;
                            end else begin
                                rd_idx     <= rd_next;
                                pkt_data_o <= buffer[rd_next];
                                pkt_sof_o  <= 1'b0;
                                pkt_eof_o  <= ({1'b0, rd_next} == pkt_len_o - 5'd1);
                            end
                        end
                    end
                    default: begin
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: a table of whole frames with expected payload/errors,
// followed by hand-written timeout, back-pressure, reset and frame-error sequences.
module tb_uart_rx_pkt_ctrl;

    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data_i = '0;
    logic       rx_vld_i = 1'b0;
    logic       rx_rdy_o;
    logic       rx_frame_error_i = 1'b0;
    logic [7:0] pkt_data_o;
    logic       pkt_vld_o;
    logic       pkt_rdy_i = 1'b1;
    logic       pkt_sof_o;
    logic       pkt_eof_o;
    logic [4:0] pkt_len_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic       busy_o;

    uart_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .rx_data_i(rx_data_i), .rx_vld_i(rx_vld_i), .rx_rdy_o(rx_rdy_o),
        .rx_frame_error_i(rx_frame_error_i),
        .pkt_data_o(pkt_data_o), .pkt_vld_o(pkt_vld_o), .pkt_rdy_i(pkt_rdy_i),
        .pkt_sof_o(pkt_sof_o), .pkt_eof_o(pkt_eof_o), .pkt_len_o(pkt_len_o),
        .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] out_data_q [$];
    logic       out_sof_q  [$];
    logic       out_eof_q  [$];
    logic [4:0] out_len_q  [$];
    logic [1:0] err_q      [$];

    // Transfers and error pulses are logged on the falling edge, half a cycle before they commit.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_vld_o && pkt_rdy_i) begin
                out_data_q.push_back(pkt_data_o);
                out_sof_q.push_back(pkt_sof_o);
                out_eof_q.push_back(pkt_eof_o);
                out_len_q.push_back(pkt_len_o);
            end
            if (err_o) err_q.push_back(err_code_o);
        end
    end

    typedef struct {
        string        name;
        int           n_in;
        logic [159:0] in_bytes;
        int           n_out;
        logic [127:0] out_bytes;
        logic [4:0]   exp_len;
        int           n_err;
        logic [1:0]   exp_code;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearQueues();
        out_data_q.delete(); out_sof_q.delete(); out_eof_q.delete();
        out_len_q.delete(); err_q.delete();
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit done = 0;
        rx_data_i = b;
        rx_vld_i  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rx_rdy_o) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        rx_vld_i = 1'b0;
        if (!done) checkOutput($sformatf("send_%02h_accepted", b), 0, 1);
    endtask

    task automatic waitIdle(input string name);
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (!busy_o) idle = 1;
        end
        if (!idle) checkOutput({name, ".idle"}, 0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearQueues();
        for (int i = 0; i < v.n_in; i++) sendByte(v.in_bytes[(v.n_in - 1 - i) * 8 +: 8]);
        waitIdle(v.name);
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".nout"}, out_data_q.size(), v.n_out);
        for (int j = 0; j < v.n_out; j++) begin
            if (j < out_data_q.size()) begin
                checkOutput($sformatf("%s.data%0d", v.name, j), out_data_q[j],
                            v.out_bytes[(v.n_out - 1 - j) * 8 +: 8]);
                checkOutput($sformatf("%s.sof%0d", v.name, j), out_sof_q[j], (j == 0) ? 1 : 0);
                checkOutput($sformatf("%s.eof%0d", v.name, j), out_eof_q[j], (j == v.n_out - 1) ? 1 : 0);
                checkOutput($sformatf("%s.len%0d", v.name, j), out_len_q[j], v.exp_len);
            end
        end
        checkOutput({v.name, ".nerr"}, err_q.size(), v.n_err);
        if (v.n_err > 0 && err_q.size() > 0) checkOutput({v.name, ".code"}, err_q[0], v.exp_code);
    endtask

    initial begin
        bit         stable_ok;
        bit         eof_done;
        bit         got;
        bit         acc_ok;
        int         k;

        vecs[0] = '{name:"good3",   n_in:7,  in_bytes:160'h55A50311223303, n_out:3,
                    out_bytes:128'h112233, exp_len:5'd3, n_err:0, exp_code:2'd0};
        vecs[1] = '{name:"badcsum", n_in:6,  in_bytes:160'hA50311223304, n_out:0,
                    out_bytes:128'h0, exp_len:5'd0, n_err:1, exp_code:2'd2};
        vecs[2] = '{name:"len1",    n_in:4,  in_bytes:160'hA5017E7F, n_out:1,
                    out_bytes:128'h7E, exp_len:5'd1, n_err:0, exp_code:2'd0};
        vecs[3] = '{name:"len0",    n_in:2,  in_bytes:160'hA500, n_out:0,
                    out_bytes:128'h0, exp_len:5'd0, n_err:1, exp_code:2'd1};
        vecs[4] = '{name:"len17",   n_in:2,  in_bytes:160'hA511, n_out:0,
                    out_bytes:128'h0, exp_len:5'd0, n_err:1, exp_code:2'd1};
        vecs[5] = '{name:"len2",    n_in:5,  in_bytes:160'hA502AA55FD, n_out:2,
                    out_bytes:128'hAA55, exp_len:5'd2, n_err:0, exp_code:2'd0};
        vecs[6] = '{name:"len16",   n_in:19, in_bytes:160'hA510_000102030405060708090A0B0C0D0E0F_10, n_out:16,
                    out_bytes:128'h000102030405060708090A0B0C0D0E0F, exp_len:5'd16, n_err:0, exp_code:2'd0};
        vecs[7] = '{name:"hdrlen",  n_in:2,  in_bytes:160'hA5A5, n_out:0,
                    out_bytes:128'h0, exp_len:5'd0, n_err:1, exp_code:2'd1};
        vecs[8] = '{name:"noise",   n_in:6,  in_bytes:160'h00FFA5010001, n_out:1,
                    out_bytes:128'h00, exp_len:5'd1, n_err:0, exp_code:2'd0};

        $display("[TB] reset phase");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.rx_rdy", rx_rdy_o, 0);
        checkOutput("rst.vld", pkt_vld_o, 0);
        checkOutput("rst.sof_eof", {pkt_sof_o, pkt_eof_o}, 0);
        checkOutput("rst.len", pkt_len_o, 0);
        checkOutput("rst.data", pkt_data_o, 0);
        checkOutput("rst.err", {err_o, err_code_o}, 0);
        checkOutput("rst.busy", busy_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst.rx_rdy_after", rx_rdy_o, 1);
        @(posedge clk); #1;

        $display("[TB] frame table");
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v]);
            checkVector(vecs[v]);
        end

        $display("[TB] timeout sequence");
        clearQueues();
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h10);
        k = 0;
        for (int i = 1; i <= 100 && k == 0; i++) begin
            @(posedge clk); #1;
            if (err_o) k = i;
        end
        checkOutput("tout.cycles", k, TIMEOUT_CYC);
        checkOutput("tout.code", err_code_o, 3);
        waitIdle("tout");
        checkOutput("tout.nerr", err_q.size(), 1);
        checkOutput("tout.nout", out_data_q.size(), 0);

        $display("[TB] back-pressure sequence");
        clearQueues();
        pkt_rdy_i = 1'b0;
        sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h03);
        checkOutput("bp.vld_next_cycle", pkt_vld_o, 1);
        checkOutput("bp.first", {pkt_data_o, pkt_sof_o, pkt_eof_o}, {8'h11, 1'b1, 1'b0});
        rx_data_i = 8'h55;
        rx_vld_i  = 1'b1;
        stable_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!pkt_vld_o || pkt_data_o != 8'h11 || !pkt_sof_o || pkt_eof_o || rx_rdy_o) stable_ok = 0;
        end
        checkOutput("bp.hold_stable", stable_ok, 1);
        @(posedge clk); #1;
        pkt_rdy_i = 1'b1;
        eof_done = 0; got = 0; acc_ok = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rx_rdy_o) begin
                got    = 1;
                acc_ok = eof_done;
            end
            if (pkt_vld_o && pkt_eof_o) eof_done = 1;
        end
        @(posedge clk); #1;
        rx_vld_i = 1'b0;
        checkOutput("bp.pending_after_eof", acc_ok, 1);
        waitIdle("bp");
        checkOutput("bp.nout", out_data_q.size(), 3);
        if (out_data_q.size() == 3)
            checkOutput("bp.bytes", {out_data_q[0], out_data_q[1], out_data_q[2]}, 24'h112233);

        $display("[TB] reset during payload");
        clearQueues();
        sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstmid.outs", {pkt_vld_o, pkt_sof_o, pkt_eof_o, err_o, busy_o, rx_rdy_o}, 0);
        checkOutput("rstmid.len_code", {pkt_len_o, err_code_o}, 0);
        checkOutput("rstmid.data", pkt_data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rstmid.busy_after", busy_o, 0);
        checkOutput("rstmid.nerr", err_q.size(), 0);
        checkOutput("rstmid.nout", out_data_q.size(), 0);

        $display("[TB] frame-error sequences");
        clearQueues();
        sendByte(8'hA5); sendByte(8'h00);
        waitIdle("fe.pre");
        checkOutput("fe.pre_code", err_code_o, 1);
        clearQueues();
        rx_frame_error_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_frame_error_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("fe.hunt_ignored", err_q.size(), 0);
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h10); sendByte(8'h20);
        rx_frame_error_i = 1'b1;
        sendByte(8'h32);
        waitIdle("fe.csum");
        rx_frame_error_i = 1'b0;
        checkOutput("fe.nerr", err_q.size(), 1);
        if (err_q.size() > 0) checkOutput("fe.code", err_q[0], 0);
        checkOutput("fe.code_held", err_code_o, 0);
        checkOutput("fe.nout", out_data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
